// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the Riscv151 instruction-fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;

    typedef enum logic [1:0] {
        PCSEL_PLUS4 = 2'd0,
        PCSEL_ALU   = 2'd1
    } pcSel_e;

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_KILL,
        SRC_REDIRECT,
        SRC_HOLD,
        SRC_PLUS4
    } nextPcSrc_e;

    // Jump targets are half-word aligned by clearing bit 0 of the ALU result.
    function automatic logic [31:0] alignTarget(input logic [31:0] target);
        return {target[31:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of controller, datapath and ICache signals around the fetch stage.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic [1:0]  pc_sel;
    logic        inst_kill;
    logic [31:0] alu_out;
    logic        stall;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout;
    logic [31:0] inst_I;
    logic        inst_valid_I;
    logic [31:0] pc_I;
    logic [31:0] pc_X;
    logic [31:0] pc_plus4_M;
    logic [31:0] fetch_count;

    modport master (
        input  pc_sel, inst_kill, alu_out, stall, icache_dout,
        output icache_addr, icache_re, inst_I, inst_valid_I,
               pc_I, pc_X, pc_plus4_M, fetch_count
    );

    modport slave (
        output pc_sel, inst_kill, alu_out, stall, icache_dout,
        input  icache_addr, icache_re, inst_I, inst_valid_I,
               pc_I, pc_X, pc_plus4_M, fetch_count
    );

endinterface

// File: rtl/fetch_unit_next_pc_mux.sv
// Priority mux that picks the next fetch address, including target alignment.
module fetch_unit_next_pc_mux
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        inReset_i,
    input  logic        killAlu_i,
    input  logic        redirectPending_i,
    input  logic        stall_i,
    input  logic [31:0] aluOut_i,
    input  logic [31:0] redirectPc_i,
    input  logic [31:0] pcI_i,
    output logic [31:0] nextPc_o
);

    nextPcSrc_e src;

    // Resolve which source owns the next PC: reset, live jump, deferred jump, stall hold, or sequential.
    always_comb begin
        src = SRC_PLUS4;
        if (inReset_i) begin
            src = SRC_RESET;
        end else if (killAlu_i && !stall_i) begin
            src = SRC_KILL;
        end else if (redirectPending_i && !stall_i) begin
            src = SRC_REDIRECT;
        end else if (stall_i) begin
            src = SRC_HOLD;
        end
    end

    // Drive the address for the selected source; holding pc_I keeps the synchronous RAM output stable.
    always_comb begin
        nextPc_o = pcI_i + 32'd4;
        case (src)
            SRC_RESET:    nextPc_o = RESET_PC;
            SRC_KILL:     nextPc_o = alignTarget(aluOut_i);
            SRC_REDIRECT: nextPc_o = redirectPc_i;
            SRC_HOLD:     nextPc_o = pcI_i;
            default:      ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, ICache port, kill bubbles, stalled-redirect memory and PC pipeline copies.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    logic        inReset;
    logic        killAlu;
    logic        killSel;
    logic        instValid;
    logic [31:0] nextPc;

    logic [31:0] pcI_q,             pcI_d;
    logic [31:0] pcX_q,             pcX_d;
    logic [31:0] pcPlus4M_q,        pcPlus4M_d;
    logic [31:0] fetchCount_q,      fetchCount_d;
    logic        redirectPending_q, redirectPending_d;
    logic [31:0] redirectPc_q,      redirectPc_d;

    assign inReset   = ~reset;
    assign killAlu   = bus.inst_kill && (bus.pc_sel == PCSEL_ALU);
    assign killSel   = bus.inst_kill | redirectPending_q | inReset;
    assign instValid = ~killSel;

    fetch_unit_next_pc_mux #(
        .RESET_PC (RESET_PC)
    ) u_nextPcMux (
        .inReset_i         (inReset),
        .killAlu_i         (killAlu),
        .redirectPending_i (redirectPending_q),
        .stall_i           (bus.stall),
        .aluOut_i          (bus.alu_out),
        .redirectPc_i      (redirectPc_q),
        .pcI_i             (pcI_q),
        .nextPc_o          (nextPc)
    );

    assign bus.icache_addr  = nextPc;
    assign bus.icache_re    = 1'b1;
    assign bus.inst_I       = killSel ? NOP_INST : bus.icache_dout;
    assign bus.inst_valid_I = instValid;
    assign bus.pc_I         = pcI_q;
    assign bus.pc_X         = pcX_q;
    assign bus.pc_plus4_M   = pcPlus4M_q;
    assign bus.fetch_count  = fetchCount_q;

    // Next-state: remember a jump that arrives while frozen, and advance the PC copies only when not stalled.
    always_comb begin
        pcI_d             = nextPc;
        pcX_d             = pcX_q;
        pcPlus4M_d        = pcPlus4M_q;
        fetchCount_d      = fetchCount_q;
        redirectPending_d = redirectPending_q;
        redirectPc_d      = redirectPc_q;
        if (killAlu && bus.stall) begin
            redirectPending_d = 1'b1;
            redirectPc_d      = alignTarget(bus.alu_out);
        end else if (!bus.stall) begin
            redirectPending_d = 1'b0;
        end
        if (!bus.stall) begin
            pcX_d        = pcI_q;
            pcPlus4M_d   = pcX_q + 32'd4;
            fetchCount_d = fetchCount_q + {31'd0, instValid};
        end
    end

    // State registers with synchronous active-low reset; reset also discards any deferred redirect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pcI_q             <= RESET_PC;
            pcX_q             <= 32'd0;
            pcPlus4M_q        <= 32'd0;
            fetchCount_q      <= 32'd0;
            redirectPending_q <= 1'b0;
            redirectPc_q      <= 32'd0;
        end else begin
            pcI_q             <= pcI_d;
            pcX_q             <= pcX_d;
            pcPlus4M_q        <= pcPlus4M_d;
            fetchCount_q      <= fetchCount_d;
            redirectPending_q <= redirectPending_d;
            redirectPc_q      <= redirectPc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset corner sequence, random run against a reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RPC = 32'h4000_0000;

    typedef struct {
        logic        stall;
        logic        kill;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] pcI;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] cnt;
        logic [31:0] pcX;
        logic [31:0] p4M;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   passes;

    logic [31:0] mPc, mPcX, mP4M, mCnt, mRedir;
    logic        mPend;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RPC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock generator.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents are a fixed function of the address.
    function automatic logic [31:0] instAt(input logic [31:0] a);
        return a ^ 32'hC0DE_F00D;
    endfunction

    // Synchronous-read ICache model: data appears the cycle after its address.
    always @(posedge clk) begin
        if (bus.icache_re) bus.icache_dout <= instAt(bus.icache_addr);
    end

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        else passes++;
    endtask

    task automatic applyStimulus(input logic rstN, input logic stall, input logic kill,
                                 input logic [1:0] sel, input logic [31:0] alu);
        reset         = rstN;
        bus.stall     = stall;
        bus.inst_kill = kill;
        bus.pc_sel    = sel;
        bus.alu_out   = alu;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] pcI, input logic [31:0] addr,
                               input logic valid, input logic [31:0] cnt,
                               input logic [31:0] pcX, input logic [31:0] p4M);
        checkEq({tag, " pc_I"}, bus.pc_I, pcI);
        checkEq({tag, " icache_addr"}, bus.icache_addr, addr);
        checkEq({tag, " inst_valid_I"}, {31'd0, bus.inst_valid_I}, {31'd0, valid});
        checkEq({tag, " inst_I"}, bus.inst_I, valid ? instAt(pcI) : NOP_INST);
        checkEq({tag, " fetch_count"}, bus.fetch_count, cnt);
        checkEq({tag, " pc_X"}, bus.pc_X, pcX);
        checkEq({tag, " pc_plus4_M"}, bus.pc_plus4_M, p4M);
        checkEq({tag, " icache_re"}, {31'd0, bus.icache_re}, 32'd1);
    endtask

    task automatic endCycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkVec(input logic stall, input logic kill, input logic [1:0] sel,
                                   input logic [31:0] alu, input logic [31:0] pcI, input logic [31:0] addr,
                                   input logic valid, input logic [31:0] cnt,
                                   input logic [31:0] pcX, input logic [31:0] p4M);
        vec_t v;
        v.stall = stall; v.kill = kill; v.sel = sel; v.alu = alu;
        v.pcI = pcI; v.addr = addr; v.valid = valid; v.cnt = cnt; v.pcX = pcX; v.p4M = p4M;
        return v;
    endfunction

    // Expected fetch address and validity for the current cycle, from the priority rules.
    task automatic modelExpect(input logic rstN, input logic stall, input logic kill, input logic [1:0] sel,
                               input logic [31:0] alu, output logic [31:0] addr, output logic valid);
        logic jumpNow;
        jumpNow = kill && (sel == 2'd1);
        if (!rstN)                 addr = RPC;
        else if (jumpNow && !stall) addr = alu & ~32'd1;
        else if (mPend && !stall)  addr = mRedir;
        else if (stall)            addr = mPc;
        else                       addr = mPc + 32'd4;
        valid = rstN && !kill && !mPend;
    endtask

    // Move the reference model across one clock edge.
    task automatic modelAdvance(input logic rstN, input logic stall, input logic kill, input logic [1:0] sel,
                                input logic [31:0] alu, input logic [31:0] addr, input logic valid);
        if (!rstN) begin
            mPc = RPC; mPcX = 32'd0; mP4M = 32'd0; mCnt = 32'd0; mPend = 1'b0; mRedir = 32'd0;
        end else begin
            if (!stall) begin
                mP4M = mPcX + 32'd4;
                mPcX = mPc;
                mCnt = mCnt + (valid ? 32'd1 : 32'd0);
            end
            if (kill && (sel == 2'd1) && stall) begin
                mPend  = 1'b1;
                mRedir = alu & ~32'd1;
            end else if (!stall) begin
                mPend = 1'b0;
            end
            mPc = addr;
        end
    endtask

    initial begin
        vec_t        vecs[26];
        logic        rS, rK, rR, eValid;
        logic [1:0]  rSel;
        logic [31:0] rAlu, eAddr;

        checks = 0;
        passes = 0;
        bus.icache_dout = 32'd0;

        vecs[0]  = mkVec(0,0,0,32'h0,        32'h4000_0000,32'h4000_0004,1, 0, 32'h0,        32'h0);
        vecs[1]  = mkVec(0,0,0,32'h0,        32'h4000_0004,32'h4000_0008,1, 1, 32'h4000_0000,32'h4);
        vecs[2]  = mkVec(0,0,0,32'h0,        32'h4000_0008,32'h4000_000C,1, 2, 32'h4000_0004,32'h4000_0004);
        vecs[3]  = mkVec(0,0,0,32'h0,        32'h4000_000C,32'h4000_0010,1, 3, 32'h4000_0008,32'h4000_0008);
        vecs[4]  = mkVec(0,1,1,32'h4000_0101,32'h4000_0010,32'h4000_0100,0, 4, 32'h4000_000C,32'h4000_000C);
        vecs[5]  = mkVec(0,0,0,32'h0,        32'h4000_0100,32'h4000_0104,1, 4, 32'h4000_0010,32'h4000_0010);
        vecs[6]  = mkVec(0,1,1,32'h4000_0020,32'h4000_0104,32'h4000_0020,0, 5, 32'h4000_0100,32'h4000_0014);
        vecs[7]  = mkVec(1,0,0,32'h0,        32'h4000_0020,32'h4000_0020,1, 5, 32'h4000_0104,32'h4000_0104);
        vecs[8]  = mkVec(1,0,0,32'h0,        32'h4000_0020,32'h4000_0020,1, 5, 32'h4000_0104,32'h4000_0104);
        vecs[9]  = mkVec(1,0,0,32'h0,        32'h4000_0020,32'h4000_0020,1, 5, 32'h4000_0104,32'h4000_0104);
        vecs[10] = mkVec(0,0,0,32'h0,        32'h4000_0020,32'h4000_0024,1, 5, 32'h4000_0104,32'h4000_0104);
        vecs[11] = mkVec(0,0,0,32'h0,        32'h4000_0024,32'h4000_0028,1, 6, 32'h4000_0020,32'h4000_0108);
        vecs[12] = mkVec(1,1,1,32'h4000_0200,32'h4000_0028,32'h4000_0028,0, 7, 32'h4000_0024,32'h4000_0024);
        vecs[13] = mkVec(1,0,0,32'h0,        32'h4000_0028,32'h4000_0028,0, 7, 32'h4000_0024,32'h4000_0024);
        vecs[14] = mkVec(0,0,0,32'h0,        32'h4000_0028,32'h4000_0200,0, 7, 32'h4000_0024,32'h4000_0024);
        vecs[15] = mkVec(0,0,0,32'h0,        32'h4000_0200,32'h4000_0204,1, 7, 32'h4000_0028,32'h4000_0028);
        vecs[16] = mkVec(1,1,1,32'h4000_0300,32'h4000_0204,32'h4000_0204,0, 8, 32'h4000_0200,32'h4000_002C);
        vecs[17] = mkVec(1,1,1,32'h4000_0400,32'h4000_0204,32'h4000_0204,0, 8, 32'h4000_0200,32'h4000_002C);
        vecs[18] = mkVec(0,0,0,32'h0,        32'h4000_0204,32'h4000_0400,0, 8, 32'h4000_0200,32'h4000_002C);
        vecs[19] = mkVec(0,0,0,32'h0,        32'h4000_0400,32'h4000_0404,1, 8, 32'h4000_0204,32'h4000_0204);
        vecs[20] = mkVec(0,1,1,32'hFFFF_FFFC,32'h4000_0404,32'hFFFF_FFFC,0, 9, 32'h4000_0400,32'h4000_0208);
        vecs[21] = mkVec(0,0,0,32'h0,        32'hFFFF_FFFC,32'h0000_0000,1, 9, 32'h4000_0404,32'h4000_0404);
        vecs[22] = mkVec(0,0,0,32'h0,        32'h0000_0000,32'h0000_0004,1,10, 32'hFFFF_FFFC,32'h4000_0408);
        vecs[23] = mkVec(0,0,0,32'h0,        32'h0000_0004,32'h0000_0008,1,11, 32'h0000_0000,32'h0000_0000);
        vecs[24] = mkVec(0,1,0,32'h4000_0999,32'h0000_0008,32'h0000_000C,0,12, 32'h0000_0004,32'h0000_0004);
        vecs[25] = mkVec(0,0,0,32'h0,        32'h0000_000C,32'h0000_0010,1,12, 32'h0000_0008,32'h0000_0008);

        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        endCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        #3;
        checkEq("reset icache_addr", bus.icache_addr, RPC);
        checkEq("reset inst_valid_I", {31'd0, bus.inst_valid_I}, 32'd0);
        checkEq("reset inst_I", bus.inst_I, NOP_INST);
        endCycle();

        for (int i = 0; i < 26; i++) begin
            applyStimulus(1'b1, vecs[i].stall, vecs[i].kill, vecs[i].sel, vecs[i].alu);
            #3;
            checkOutput($sformatf("row%0d", i), vecs[i].pcI, vecs[i].addr, vecs[i].valid,
                        vecs[i].cnt, vecs[i].pcX, vecs[i].p4M);
            endCycle();
        end

        applyStimulus(1'b1, 1'b1, 1'b1, 2'd1, 32'h4000_0700);
        #3;
        checkEq("midredir kill valid", {31'd0, bus.inst_valid_I}, 32'd0);
        endCycle();
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 32'h0);
        #3;
        checkEq("midredir reset addr", bus.icache_addr, RPC);
        checkEq("midredir reset inst", bus.inst_I, NOP_INST);
        endCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 32'h0);
        #3;
        checkOutput("after midredir reset", RPC, RPC + 32'd4, 1'b1, 32'd0, 32'd0, 32'd0);
        endCycle();

        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        endCycle();
        mPc = RPC; mPcX = 32'd0; mP4M = 32'd0; mCnt = 32'd0; mPend = 1'b0; mRedir = 32'd0;

        for (int c = 0; c < 400; c++) begin
            rR   = ($urandom_range(0, 49) != 0);
            rS   = ($urandom_range(0, 3) == 0);
            rK   = ($urandom_range(0, 6) == 0);
            rSel = ($urandom_range(0, 3) != 0) ? 2'd1 : 2'($urandom_range(0, 3));
            rAlu = 32'h4000_0000 | $urandom_range(0, 4095);
            applyStimulus(rR, rS, rK, rSel, rAlu);
            modelExpect(rR, rS, rK, rSel, rAlu, eAddr, eValid);
            #3;
            checkOutput($sformatf("rand%0d", c), mPc, eAddr, eValid, mCnt, mPcX, mP4M);
            endCycle();
            modelAdvance(rR, rS, rK, rSel, rAlu, eAddr, eValid);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
